mux_mode_ctrl: RTL and testbench
================================

Name: mux_mode_ctrl

Overview:
Sequencing controller for the video mux select lines (background source, overlay/target source). It takes user button pulses and an optional auto-cycle timer, holds requested modes as pending, and commits them only at frame boundaries so the display never tears mid-frame. It also forces the overlay from sprite to crosshair when centre-of-mass tracking is lost, and restores sprite when tracking returns. It sits between the button debouncers/frame timing and the video mux.

Parameters:
AUTO_FRAMES, 120, frames between automatic background advances when auto mode is enabled (>=1)
LOST_FRAMES, 8, consecutive frames without a valid centre of mass before sprite overlay falls back to crosshair (>=1)
ALLOW_TEST, 0, 1 = target cycling includes test-colour mode 2'b11; 0 = skipped

Ports:
clk_in  input  1  system pixel clock
rst_in  input  1  synchronous, active-low reset
btn_bg_in  input  1  one-cycle pulse: advance pending background mode
btn_target_in  input  1  one-cycle pulse: advance pending target mode
new_frame_in  input  1  one-cycle pulse at start of vertical blank; commit point
auto_en_in  input  1  level: enable automatic background cycling
com_valid_in  input  1  level: centre-of-mass result valid; sampled only on new_frame_in
bg_out  output  2  committed background select to mux
target_out  output  2  committed (effective) target select to mux
bg_pend_out  output  2  pending background mode (for status display)
tgt_pend_out  output  2  pending target mode, before fallback
lost_out  output  1  1 while tracker FSM is in LOST
mode_changed_out  output  1  one-cycle pulse when a commit changes bg_out or target_out

Behaviour:
- Reset (rst_in=0 at a clock edge): all outputs 0, pending regs 0, both counters 0, FSM = TRACK. Reset overrides all inputs in the same cycle.
- Pending bg: btn_bg_in pulse -> bg_pend +1 mod 4 (3 wraps to 0).
- Pending target: btn_target_in pulse -> 00->01->10->00 when ALLOW_TEST=0; 00->01->10->11->00 when ALLOW_TEST=1.
- Auto counter (width $clog2(AUTO_FRAMES+1)): cleared while auto_en_in=0. With auto_en_in=1, increments on each new_frame_in. On new_frame_in with count==AUTO_FRAMES-1, request a bg advance and clear the counter. btn_bg_in also clears it (same-cycle clear wins over increment).
- Simultaneous btn_bg_in and auto advance in one cycle: bg_pend advances exactly once (+1, not +2).
- Tracker FSM, evaluated only on new_frame_in:
  - Lost counter saturates at LOST_FRAMES.
  - com_valid_in=1 -> counter := 0, state TRACK.
  - com_valid_in=0 -> counter +1; when it reaches LOST_FRAMES, state LOST.
  - lost_out = (state==LOST), updated the same edge as the counter.
- Effective target = 2'b01 if tgt_pend==2'b10 and the next FSM state is LOST; otherwise tgt_pend.
- Commit: on new_frame_in, registered at the same edge:
  - bg_out <= bg_pend value before any same-cycle button/auto increment.
  - target_out <= effective target, using the pre-increment tgt_pend.
  - A button pulse coinciding with new_frame_in takes effect at the next frame.
  - Latency: a button press reaches the mux at the first new_frame_in strictly after the press; commit edge +0 cycles.
- mode_changed_out: 1 for the single cycle after a commit edge where bg_out or target_out changed value; otherwise 0.
- Between commits, bg_out and target_out are stable regardless of button, auto_en_in or com_valid_in activity.
- Reset mid-frame: pending presses are discarded and outputs go to 00/00 immediately, not waiting for a frame boundary.

Decomposition:
- Package video_mux_pkg:
  - bg_mode_t enum {BG_CAMERA=0, BG_CHANNEL=1, BG_THRESH=2, BG_YMASK=3}
  - tgt_mode_t enum {TGT_NONE=0, TGT_CROSSHAIR=1, TGT_SPRITE=2, TGT_TEST=3}
  - tracker state enum {TRK_TRACK, TRK_LOST}
- One sub-module: frame_event_counter, a parameterised counter advanced by a qualified event with clear, terminal-count flag and saturate-or-wrap select. Instantiated twice: auto counter (wrap) and lost counter (saturate).

Test Plan:
- Reset, then 3 btn_bg_in pulses with no new_frame_in -> bg_pend_out=3, bg_out=0. Next new_frame_in -> bg_out=3, mode_changed_out high exactly 1 cycle.
- btn_target_in pulses with ALLOW_TEST=0 -> tgt_pend 1,2,0. Rerun with ALLOW_TEST=1 -> 1,2,3,0. target_out changes only on new_frame_in.
- btn_bg_in in the same cycle as new_frame_in, bg_pend=1 -> bg_out=1 at that commit, bg_pend=2, bg_out=2 at the next frame.
- AUTO_FRAMES=4, auto_en_in=1, 12 frames -> bg_out advances every 4th frame (0->1->2->3). A btn_bg_in coincident with a terminal frame advances bg_pend once only.
- tgt_pend=2, LOST_FRAMES=3, com_valid_in=0 for 3 frames -> lost_out and target_out=1 at frame 3. com_valid_in=1 at frame 5 -> target_out=2, lost_out=0 on that frame.
- Assert rst_in=0 mid-frame with pending changes -> all outputs 0 next edge; no mode_changed_out pulse on the next frame.

Source files
------------

// File: rtl/video_mux_pkg.sv
// Shared mode encodings for the video mux select path and the tracker state.
// Pure types and one helper function; no timing or flow control.
package video_mux_pkg;

  typedef enum logic [1:0] {
    BG_CAMERA  = 2'd0,
    BG_CHANNEL = 2'd1,
    BG_THRESH  = 2'd2,
    BG_YMASK   = 2'd3
  } bg_mode_t;

  typedef enum logic [1:0] {
    TGT_NONE      = 2'd0,
    TGT_CROSSHAIR = 2'd1,
    TGT_SPRITE    = 2'd2,
    TGT_TEST      = 2'd3
  } tgt_mode_t;

  typedef enum logic {
    TRK_TRACK = 1'b0,
    TRK_LOST  = 1'b1
  } trk_state_t;

  // Test-colour mode is only reachable when the build allows it.
  function automatic tgt_mode_t next_tgt(input tgt_mode_t cur, input logic allow_test);
    case (cur)
      TGT_NONE:      return TGT_CROSSHAIR;
      TGT_CROSSHAIR: return TGT_SPRITE;
      TGT_SPRITE:    return allow_test ? TGT_TEST : TGT_NONE;
      default:       return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_event_counter.sv
// Event counter with clear; tc_out flags an event that brings the count to TERM.
// Latency: tc_out combinational, count updates next edge; no backpressure (events never stall).
module frame_event_counter #(
  parameter int TERM     = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic evt_in,
  output logic tc_out
);

  localparam int W = $clog2(TERM + 1);
  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] PRE_V  = W'(TERM - 1);

  logic [W-1:0] count;
  logic         at_pre;
  logic         at_term;

  assign at_pre  = (count == PRE_V);
  assign at_term = (count == TERM_V);
  // In wrap mode the count never rests at TERM, so at_term only matters when saturating.
  assign tc_out  = evt_in & (at_pre | (SATURATE & at_term));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (clr_in) begin
      count <= '0;
    end else if (evt_in) begin
      if (tc_out) count <= SATURATE ? TERM_V : '0;
      else        count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mux_mode_ctrl.sv
// Holds requested bg/target modes as pending and commits them to the mux on new_frame_in.
// Latency: commit at the frame edge, press visible at the first frame strictly after it; no backpressure.
module mux_mode_ctrl
  import video_mux_pkg::*;
#(
  parameter int AUTO_FRAMES = 120,
  parameter int LOST_FRAMES = 8,
  parameter int ALLOW_TEST  = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       new_frame_in,
  input  logic       auto_en_in,
  input  logic       com_valid_in,
  output logic [1:0] bg_out,
  output logic [1:0] target_out,
  output logic [1:0] bg_pend_out,
  output logic [1:0] tgt_pend_out,
  output logic       lost_out,
  output logic       mode_changed_out
);

  trk_state_t state, state_next;
  bg_mode_t   bg_pend, bg_q;
  tgt_mode_t  tgt_pend, tgt_q, tgt_eff;
  logic       changed_q;
  logic       auto_fire;
  logic       lost_hit;

  // Auto advance still fires when a button clears the counter the same cycle.
  frame_event_counter #(.TERM(AUTO_FRAMES), .SATURATE(1'b0)) u_auto_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr_in (~auto_en_in | btn_bg_in),
    .evt_in (auto_en_in & new_frame_in),
    .tc_out (auto_fire)
  );

  frame_event_counter #(.TERM(LOST_FRAMES), .SATURATE(1'b1)) u_lost_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr_in (new_frame_in & com_valid_in),
    .evt_in (new_frame_in & ~com_valid_in),
    .tc_out (lost_hit)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= TRK_TRACK;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    tgt_eff    = tgt_pend;
    if (new_frame_in) begin
      if (com_valid_in) state_next = TRK_TRACK;
      else if (lost_hit) state_next = TRK_LOST;
    end
    if (tgt_pend == TGT_SPRITE && state_next == TRK_LOST) tgt_eff = TGT_CROSSHAIR;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bg_pend   <= BG_CAMERA;
      tgt_pend  <= TGT_NONE;
      bg_q      <= BG_CAMERA;
      tgt_q     <= TGT_NONE;
      changed_q <= 1'b0;
    end else begin
      if (btn_bg_in | auto_fire) bg_pend <= bg_mode_t'(bg_pend + 2'd1);
      if (btn_target_in)         tgt_pend <= next_tgt(tgt_pend, ALLOW_TEST != 0);
      changed_q <= 1'b0;
      // Commit uses the pre-increment pending values; same-cycle presses land next frame.
      if (new_frame_in) begin
        bg_q      <= bg_pend;
        tgt_q     <= tgt_eff;
        changed_q <= (bg_pend != bg_q) || (tgt_eff != tgt_q);
      end
    end
  end

  assign bg_out           = bg_q;
  assign target_out       = tgt_q;
  assign bg_pend_out      = bg_pend;
  assign tgt_pend_out     = tgt_pend;
  assign lost_out         = (state == TRK_LOST);
  assign mode_changed_out = changed_q;

endmodule

// File: tb/tb_mux_mode_ctrl.sv
// Drives two controllers (test mode off/on) with directed and random stimulus against a frame-level model.
module tb_mux_mode_ctrl;

  localparam int AUTO = 4;
  localparam int LOST = 3;

  logic clk = 1'b0;
  logic rst_n, btn_bg, btn_tgt, new_frame, auto_en, com_valid;
  logic [1:0][1:0] bg_o, tgt_o, bgp_o, tgp_o;
  logic [1:0]      lost_o, chg_o;

  int total = 0;
  int bad   = 0;

  int m_bgp[2], m_tgp[2], m_bgo[2], m_tgo[2], m_acnt[2], m_lcnt[2];
  bit m_chg[2], m_lost[2];

  always #5 clk = ~clk;

  mux_mode_ctrl #(.AUTO_FRAMES(AUTO), .LOST_FRAMES(LOST), .ALLOW_TEST(0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .btn_bg_in(btn_bg), .btn_target_in(btn_tgt),
    .new_frame_in(new_frame), .auto_en_in(auto_en), .com_valid_in(com_valid),
    .bg_out(bg_o[0]), .target_out(tgt_o[0]), .bg_pend_out(bgp_o[0]),
    .tgt_pend_out(tgp_o[0]), .lost_out(lost_o[0]), .mode_changed_out(chg_o[0]));

  mux_mode_ctrl #(.AUTO_FRAMES(AUTO), .LOST_FRAMES(LOST), .ALLOW_TEST(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .btn_bg_in(btn_bg), .btn_target_in(btn_tgt),
    .new_frame_in(new_frame), .auto_en_in(auto_en), .com_valid_in(com_valid),
    .bg_out(bg_o[1]), .target_out(tgt_o[1]), .bg_pend_out(bgp_o[1]),
    .tgt_pend_out(tgp_o[1]), .lost_out(lost_o[1]), .mode_changed_out(chg_o[1]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: lost is simply "invalid-frame run length has reached LOST".
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_bgp[i] = 0; m_tgp[i] = 0; m_bgo[i] = 0; m_tgo[i] = 0;
        m_acnt[i] = 0; m_lcnt[i] = 0; m_chg[i] = 0; m_lost[i] = 0;
      end else begin
        int  run;
        int  eff;
        bit  fire;
        run = m_lcnt[i];
        if (new_frame) run = com_valid ? 0 : ((run + 1 > LOST) ? LOST : run + 1);
        fire = auto_en && new_frame && (m_acnt[i] == AUTO - 1);
        eff  = (m_tgp[i] == 2 && run >= LOST) ? 1 : m_tgp[i];
        m_chg[i] = 0;
        if (new_frame) begin
          m_chg[i] = (m_bgp[i] != m_bgo[i]) || (eff != m_tgo[i]);
          m_bgo[i] = m_bgp[i];
          m_tgo[i] = eff;
        end
        if (!auto_en || btn_bg) m_acnt[i] = 0;
        else if (new_frame)     m_acnt[i] = (m_acnt[i] + 1) % AUTO;
        if (btn_bg || fire) m_bgp[i] = (m_bgp[i] + 1) % 4;
        if (btn_tgt)        m_tgp[i] = (m_tgp[i] + 1) % (i == 1 ? 4 : 3);
        m_lcnt[i] = run;
        m_lost[i] = (run >= LOST);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bg_out[%0d]", i), bg_o[i], m_bgo[i]);
      check($sformatf("target_out[%0d]", i), tgt_o[i], m_tgo[i]);
      check($sformatf("bg_pend[%0d]", i), bgp_o[i], m_bgp[i]);
      check($sformatf("tgt_pend[%0d]", i), tgp_o[i], m_tgp[i]);
      check($sformatf("lost[%0d]", i), lost_o[i], int'(m_lost[i]));
      check($sformatf("changed[%0d]", i), chg_o[i], int'(m_chg[i]));
    end
  endtask

  task automatic drive(input bit b, input bit t, input bit f);
    btn_bg = b; btn_tgt = t; new_frame = f;
    step();
  endtask

  initial begin
    rst_n = 1'b0; btn_bg = 1'b0; btn_tgt = 1'b0; new_frame = 1'b0;
    auto_en = 1'b0; com_valid = 1'b1;
    drive(0, 0, 0);
    drive(1, 1, 1);
    check("rst_bg_out", bg_o[0], 0);
    check("rst_bg_pend", bgp_o[1], 0);
    check("rst_lost", lost_o[0], 0);
    rst_n = 1'b1;

    // Three bg presses held pending, then one frame commits them.
    for (int k = 0; k < 3; k++) begin drive(1, 0, 0); drive(0, 0, 0); end
    check("pend3_bgp", bgp_o[0], 3);
    check("pend3_bgo", bg_o[0], 0);
    drive(0, 0, 1);
    check("commit3_bgo", bg_o[0], 3);
    check("commit3_chg", chg_o[0], 1);
    drive(0, 0, 0);
    check("commit3_chg_drop", chg_o[0], 0);

    // Target cycling with and without test mode.
    drive(0, 1, 0); check("tgt1_a0", tgp_o[0], 1); check("tgt1_a1", tgp_o[1], 1);
    drive(0, 1, 0); check("tgt2_a0", tgp_o[0], 2); check("tgt2_a1", tgp_o[1], 2);
    drive(0, 1, 0); check("tgt3_a0", tgp_o[0], 0); check("tgt3_a1", tgp_o[1], 3);
    check("tgt_hold_a1", tgt_o[1], 0);
    drive(0, 0, 1); check("tgt_commit_a1", tgt_o[1], 3);
    drive(0, 1, 0); check("tgt4_a1", tgp_o[1], 0);

    // Button coincident with a frame lands one frame later.
    drive(1, 0, 0); drive(1, 0, 0);
    drive(1, 0, 1);
    check("coinc_bgo", bg_o[0], 1);
    check("coinc_bgp", bgp_o[0], 2);
    drive(0, 0, 1);
    check("coinc_next_bgo", bg_o[0], 2);

    // Auto cycling every AUTO frames, then a button on a terminal frame.
    auto_en = 1'b1;
    drive(0, 0, 0);
    for (int k = 0; k < 12; k++) begin drive(0, 0, 1); drive(0, 0, 0); end
    check("auto12_bgp", bgp_o[0], 1);
    for (int k = 0; k < 3; k++) begin drive(0, 0, 1); drive(0, 0, 0); end
    drive(1, 0, 1);
    check("auto_btn_once", bgp_o[0], 2);
    auto_en = 1'b0;
    drive(0, 0, 0);

    // Reset with pending changes, then no change pulse on the next frame.
    drive(1, 1, 0);
    rst_n = 1'b0;
    drive(0, 0, 0);
    check("midrst_bgo", bg_o[0], 0);
    check("midrst_tgo", tgt_o[1], 0);
    rst_n = 1'b1;
    drive(0, 0, 1);
    check("midrst_nochg", chg_o[0], 0);

    // Tracking loss falls back to crosshair, recovery restores sprite.
    drive(0, 1, 0); drive(0, 1, 0);
    drive(0, 0, 1);
    check("trk_sprite", tgt_o[0], 2);
    com_valid = 1'b0;
    drive(0, 0, 1); drive(0, 0, 1);
    check("trk_f2_lost", lost_o[0], 0);
    check("trk_f2_tgt", tgt_o[0], 2);
    drive(0, 0, 1);
    check("trk_f3_lost", lost_o[0], 1);
    check("trk_f3_tgt", tgt_o[1], 1);
    drive(0, 0, 0); drive(0, 0, 1);
    check("trk_f4_tgt", tgt_o[0], 1);
    com_valid = 1'b1;
    drive(0, 0, 1);
    check("trk_f5_lost", lost_o[0], 0);
    check("trk_f5_tgt", tgt_o[0], 2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      rst_n   = ($urandom_range(0, 249) != 0);
      btn_bg  = ($urandom_range(0, 7) == 0);
      btn_tgt = ($urandom_range(0, 7) == 0);
      new_frame = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 15) == 0) com_valid = ~com_valid;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
